// File: rtl/alu_arb_pkg.sv
// Shared constants and helpers for the ALU round-robin arbiter.
// Select encoding: bits [2:0] choose the operation, bit [3] selects subtract.
package alu_arb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int SEL_W_DEF  = 4;

  localparam logic [SEL_W_DEF-1:0] OP_ADD = 4'b0000;
  localparam logic [SEL_W_DEF-1:0] OP_SUB = 4'b1000;
  localparam logic [SEL_W_DEF-1:0] OP_OR  = 4'b0110;
  localparam logic [SEL_W_DEF-1:0] OP_AND = 4'b0111;

  function automatic logic is_legal_sel(input logic [SEL_W_DEF-1:0] sel);
    logic ok;
    case (sel)
      OP_ADD, OP_SUB, OP_OR, OP_AND: ok = 1'b1;
      default:                       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with its priority pointer.
// The pointer moves to the other requester after every grant and holds otherwise.
module rr_arb2 (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] VALID,
  output logic [1:0] GRANT
);

  logic ptr_q;
  logic ptr_d;

  // Grant decode and next-pointer selection
  always_comb begin
    GRANT    = 2'b00;
    ptr_d    = ptr_q;
    GRANT[0] = VALID[0] && (!ptr_q || !VALID[1]);
    GRANT[1] = VALID[1] && (ptr_q || !VALID[0]);
    if (GRANT[0]) begin
      ptr_d = 1'b1;
    end else if (GRANT[1]) begin
      ptr_d = 1'b0;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register; a grant seen while in reset does not move it
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin front end sharing one combinational ALU between two requesters.
// Define ALU_ARB_ILLEGAL_CHK_EN to flag illegal select codes on the response.
module alu_rr_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SEL_W  = SEL_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ0_VALID,
  input  logic              REQ1_VALID,
  output logic              REQ0_READY,
  output logic              REQ1_READY,
  input  logic [DATA_W-1:0] REQ0_A,
  input  logic [DATA_W-1:0] REQ1_A,
  input  logic [DATA_W-1:0] REQ0_B,
  input  logic [DATA_W-1:0] REQ1_B,
  input  logic [SEL_W-1:0]  REQ0_SEL,
  input  logic [SEL_W-1:0]  REQ1_SEL,
  output logic [DATA_W-1:0] ALU_IN1,
  output logic [DATA_W-1:0] ALU_IN2,
  output logic [SEL_W-1:0]  SEL_ALU,
  input  logic [DATA_W-1:0] ALU_RES,
  output logic              RSP0_VALID,
  output logic              RSP1_VALID,
  output logic [DATA_W-1:0] RSP_DATA,
  output logic              RSP_ERR
);

  logic [1:0]        grant_s;
  logic [DATA_W-1:0] gnt_a_s, gnt_b_s;
  logic [SEL_W-1:0]  gnt_sel_s;

  logic [DATA_W-1:0] in1_q, in1_d, in2_q, in2_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              s1_valid_q, s1_valid_d, s1_id_q, s1_id_d, s1_err_q, s1_err_d;
  logic              rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  rr_arb2 u_rr_arb2 (
    .CLK   (CLK),
    .RST   (RST),
    .VALID ({REQ1_VALID, REQ0_VALID}),
    .GRANT (grant_s)
  );

  assign REQ0_READY = grant_s[0];
  assign REQ1_READY = grant_s[1];

  // Operand mux for the winning requester
  always_comb begin
    if (grant_s[1]) begin
      gnt_a_s   = REQ1_A;
      gnt_b_s   = REQ1_B;
      gnt_sel_s = REQ1_SEL;
    end else begin
      gnt_a_s   = REQ0_A;
      gnt_b_s   = REQ0_B;
      gnt_sel_s = REQ0_SEL;
    end
  end

  // Issue (S1) and response (S2) next-state; operand registers hold when idle
  always_comb begin
    in1_d      = in1_q;
    in2_d      = in2_q;
    sel_d      = sel_q;
    s1_valid_d = 1'b0;
    s1_id_d    = s1_id_q;
    s1_err_d   = 1'b0;
    if (grant_s != 2'b00) begin
      s1_valid_d = 1'b1;
      s1_id_d    = grant_s[1];
`ifdef ALU_ARB_ILLEGAL_CHK_EN
      if (!is_legal_sel(gnt_sel_s)) begin
        s1_err_d = 1'b1;
      end else begin
        in1_d = gnt_a_s;
        in2_d = gnt_b_s;
        sel_d = gnt_sel_s;
      end
`else
      in1_d = gnt_a_s;
      in2_d = gnt_b_s;
      sel_d = gnt_sel_s;
`endif
    end else begin
      s1_valid_d = 1'b0;
    end

    rsp0_valid_d = s1_valid_q && !s1_id_q;
    rsp1_valid_d = s1_valid_q && s1_id_q;
    rsp_err_d    = s1_valid_q && s1_err_q;
    if (s1_valid_q) begin
      rsp_data_d = s1_err_q ? {DATA_W{1'b0}} : ALU_RES;
    end else begin
      rsp_data_d = rsp_data_q;
    end
  end

  // Pipeline registers; reset drops anything in flight
  always_ff @(posedge CLK) begin
    if (RST) begin
      in1_q        <= {DATA_W{1'b0}};
      in2_q        <= {DATA_W{1'b0}};
      sel_q        <= {SEL_W{1'b0}};
      s1_valid_q   <= 1'b0;
      s1_id_q      <= 1'b0;
      s1_err_q     <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp_data_q   <= {DATA_W{1'b0}};
      rsp_err_q    <= 1'b0;
    end else begin
      in1_q        <= in1_d;
      in2_q        <= in2_d;
      sel_q        <= sel_d;
      s1_valid_q   <= s1_valid_d;
      s1_id_q      <= s1_id_d;
      s1_err_q     <= s1_err_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign ALU_IN1    = in1_q;
  assign ALU_IN2    = in2_q;
  assign SEL_ALU    = sel_q;
  assign RSP0_VALID = rsp0_valid_q;
  assign RSP1_VALID = rsp1_valid_q;
  assign RSP_DATA   = rsp_data_q;
  assign RSP_ERR    = rsp_err_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter: directed steps then random traffic,
// compared against a latency-queue reference model with a behavioural ALU.
module tb_alu_rr_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ0_VALID, REQ1_VALID, REQ0_READY, REQ1_READY;
  logic [31:0] REQ0_A, REQ1_A, REQ0_B, REQ1_B;
  logic [3:0]  REQ0_SEL, REQ1_SEL;
  logic [31:0] ALU_IN1, ALU_IN2, ALU_RES, RSP_DATA;
  logic [3:0]  SEL_ALU;
  logic        RSP0_VALID, RSP1_VALID, RSP_ERR;

  typedef struct {
    bit          valid;
    bit          id;
    bit          err;
    logic [31:0] data;
  } rsp_t;

  rsp_t        q[$];
  int          mptr = 0;
  logic [31:0] m_in1 = 32'h0, m_in2 = 32'h0, m_data = 32'h0;
  logic [3:0]  m_sel = 4'h0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [3:0]  sels[$];

  always #5 CLK = ~CLK;

  alu_rr_arbiter dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(REQ0_VALID), .REQ1_VALID(REQ1_VALID),
    .REQ0_READY(REQ0_READY), .REQ1_READY(REQ1_READY),
    .REQ0_A(REQ0_A), .REQ1_A(REQ1_A), .REQ0_B(REQ0_B), .REQ1_B(REQ1_B),
    .REQ0_SEL(REQ0_SEL), .REQ1_SEL(REQ1_SEL),
    .ALU_IN1(ALU_IN1), .ALU_IN2(ALU_IN2), .SEL_ALU(SEL_ALU), .ALU_RES(ALU_RES),
    .RSP0_VALID(RSP0_VALID), .RSP1_VALID(RSP1_VALID),
    .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR)
  );

  function automatic logic [31:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] s);
    case (s)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0110: return a | b;
      4'b0111: return a & b;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  function automatic bit legal_sel(input logic [3:0] s);
    return (s == 4'b0000) || (s == 4'b1000) || (s == 4'b0110) || (s == 4'b0111);
  endfunction

  // Behavioural stand-in for the external ALU
  always_comb ALU_RES = ref_op(ALU_IN1, ALU_IN2, SEL_ALU);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    int          g;
    rsp_t        e;
    rsp_t        r;
    logic [31:0] a, b;
    logic [3:0]  s;
    #1;
    if (REQ0_VALID && REQ1_VALID) g = mptr;
    else if (REQ0_VALID)          g = 0;
    else if (REQ1_VALID)          g = 1;
    else                          g = -1;
    if (!RST) begin
      chk("ready0", 32'(REQ0_READY), 32'(g == 0));
      chk("ready1", 32'(REQ1_READY), 32'(g == 1));
    end
    @(posedge CLK);
    r = '{default: 0};
    if (RST) begin
      mptr = 0;
      q.delete();
      m_in1 = 32'h0; m_in2 = 32'h0; m_sel = 4'h0; m_data = 32'h0;
    end else begin
      e = '{default: 0};
      if (g >= 0) begin
        a = (g == 1) ? REQ1_A : REQ0_A;
        b = (g == 1) ? REQ1_B : REQ0_B;
        s = (g == 1) ? REQ1_SEL : REQ0_SEL;
        mptr = (g == 0) ? 1 : 0;
        e.valid = 1'b1;
        e.id = (g == 1);
`ifdef ALU_ARB_ILLEGAL_CHK_EN
        e.err = !legal_sel(s);
`endif
        if (e.err) begin
          e.data = 32'h0;
        end else begin
          e.data = ref_op(a, b, s);
          m_in1 = a; m_in2 = b; m_sel = s;
        end
      end
      q.push_back(e);
      if (q.size() > 1) r = q.pop_front();
      if (r.valid) m_data = r.data;
    end
    #1;
    chk("rsp0_valid", 32'(RSP0_VALID), 32'(r.valid && !r.id));
    chk("rsp1_valid", 32'(RSP1_VALID), 32'(r.valid && r.id));
    chk("rsp_data", RSP_DATA, m_data);
    chk("alu_in1", ALU_IN1, m_in1);
    chk("alu_in2", ALU_IN2, m_in2);
    chk("sel_alu", 32'(SEL_ALU), 32'(m_sel));
    if (r.valid || RST) chk("rsp_err", 32'(RSP_ERR), 32'(r.err));
  endtask

  task automatic drive(input bit rst, input bit v0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [3:0] s0, input bit v1, input logic [31:0] a1,
                       input logic [31:0] b1, input logic [3:0] s1);
    RST = rst;
    REQ0_VALID = v0; REQ0_A = a0; REQ0_B = b0; REQ0_SEL = s0;
    REQ1_VALID = v1; REQ1_A = a1; REQ1_B = b1; REQ1_SEL = s1;
    tick();
  endtask

  initial begin
    sels = '{4'b0000, 4'b1000, 4'b0110, 4'b0111};
`ifdef ALU_ARB_ILLEGAL_CHK_EN
    sels.push_back(4'b0011);
`endif
    // Reset held three cycles with both requesters asking
    for (int i = 0; i < 3; i++)
      drive(1'b1, 1'b1, 32'd3, 32'd4, 4'b0000, 1'b1, 32'd9, 32'd2, 4'b1000);
    // Contention: ADD 1+1 vs SUB 0-1, expect alternating grants 0,1,0,1
    for (int i = 0; i < 4; i++)
      drive(1'b0, 1'b1, 32'd1, 32'd1, 4'b0000, 1'b1, 32'd0, 32'd1, 4'b1000);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 4'b0000, 1'b0, 32'd0, 32'd0, 4'b0000);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 4'b0000, 1'b0, 32'd0, 32'd0, 4'b0000);
    // Single add 5+7 from requester 0
    drive(1'b0, 1'b1, 32'd5, 32'd7, 4'b0000, 1'b0, 32'd0, 32'd0, 4'b0000);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 4'b0000, 1'b0, 32'd0, 32'd0, 4'b0000);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 4'b0000, 1'b0, 32'd0, 32'd0, 4'b0000);
    // Back-to-back OR then AND from requester 1
    drive(1'b0, 1'b0, 32'd0, 32'd0, 4'b0000, 1'b1, 32'hF0, 32'h0F, 4'b0110);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 4'b0000, 1'b1, 32'hFF, 32'h0F, 4'b0111);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 4'b0000, 1'b0, 32'd0, 32'd0, 4'b0000);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 4'b0000, 1'b0, 32'd0, 32'd0, 4'b0000);
    // Reset the cycle after a grant: that operation must never respond
    drive(1'b0, 1'b1, 32'd20, 32'd22, 4'b0000, 1'b0, 32'd0, 32'd0, 4'b0000);
    drive(1'b1, 1'b0, 32'd0, 32'd0, 4'b0000, 1'b0, 32'd0, 32'd0, 4'b0000);
    for (int i = 0; i < 3; i++)
      drive(1'b0, 1'b0, 32'd0, 32'd0, 4'b0000, 1'b0, 32'd0, 32'd0, 4'b0000);
`ifdef ALU_ARB_ILLEGAL_CHK_EN
    // Illegal select: accepted, flagged, operands and select held
    drive(1'b0, 1'b1, 32'd6, 32'd6, 4'b0110, 1'b0, 32'd0, 32'd0, 4'b0000);
    drive(1'b0, 1'b1, 32'd9, 32'd1, 4'b0011, 1'b0, 32'd0, 32'd0, 4'b0000);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 4'b0000, 1'b0, 32'd0, 32'd0, 4'b0000);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 4'b0000, 1'b0, 32'd0, 32'd0, 4'b0000);
`endif
    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++)
      drive(($urandom_range(0, 49) == 0),
            1'($urandom_range(0, 1)), $urandom, $urandom, sels[$urandom_range(0, sels.size() - 1)],
            1'($urandom_range(0, 1)), $urandom, $urandom, sels[$urandom_range(0, sels.size() - 1)]);
    for (int i = 0; i < 3; i++)
      drive(1'b0, 1'b0, 32'd0, 32'd0, 4'b0000, 1'b0, 32'd0, 32'd0, 4'b0000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_rr_arbiter.md
# alu_rr_arbiter

Two-requester, round-robin arbiter that shares the single-cycle combinational RISC-V ALU between the integer execute path (requester 0) and the address-generation path (requester 1). It registers the granted operands and select code onto the ALU inputs, captures the ALU result one cycle later, and returns it to the winning requester as a one-cycle response pulse. It sits between the issue logic and the ALU, and fully owns the ALU's input pins.

## Interface
- DATA_W, 32, operand and result width; must match the ALU.
- SEL_W, 4, ALU select width. Bits [2:0] are the operation; bit [3] means subtract.
- CLK  in  1  rising-edge clock
- RST  in  1  synchronous, active-high reset
- REQ0_VALID / REQ1_VALID  in  1  request present
- REQ0_READY / REQ1_READY  out  1  grant; transfer occurs when VALID&&READY
- REQ0_A / REQ1_A  in  DATA_W  operand 1
- REQ0_B / REQ1_B  in  DATA_W  operand 2
- REQ0_SEL / REQ1_SEL  in  SEL_W  ALU select code
- ALU_IN1, ALU_IN2  out  DATA_W  registered operands to the ALU
- SEL_ALU  out  SEL_W  registered select to the ALU
- ALU_RES  in  DATA_W  ALU result (the ALU's output)
- RSP0_VALID / RSP1_VALID  out  1  one-cycle response pulse per requester
- RSP_DATA  out  DATA_W  result, shared by both response channels
- RSP_ERR  out  1  illegal-op flag, qualified by RSPn_VALID

## Operation
- **Grant (combinational):**
  - READY0 = VALID0 && (PTR==0 || !VALID1).
  - READY1 = VALID1 && (PTR==1 || !VALID0).
  - At most one READY is high per cycle.
  - No request from a requester may depend on that requester's READY.
- **Round-robin pointer PTR:**
  - After a grant to requester n, PTR <= ~n.
  - PTR is unchanged in cycles with no grant.
  - A lone requester is granted every cycle.
- **Issue stage (S1):**
  - On a grant: ALU_IN1/ALU_IN2/SEL_ALU <= granted A/B/SEL; S1_VALID <= 1; S1_ID <= n.
  - With no grant: S1_VALID <= 0, and the operand registers hold their previous values (no toggling).
- **Response stage (S2):**
  - If S1_VALID: RSP_DATA <= ALU_RES; RSP<S1_ID>_VALID <= 1; the other RSP valid <= 0.
  - Otherwise both RSP valids <= 0, and RSP_DATA holds its value.
- **Pipeline occupancy states:** EMPTY, S1 only, S2 only, S1+S2. One new operation may be accepted every cycle in every state.
- **No response backpressure.** Requesters must sink RSPn_VALID in the cycle it is asserted.
- **Arithmetic:** performed entirely by the ALU, with results truncated to DATA_W. Subtract (SEL=4'b1000) yields A - B modulo 2^DATA_W, so 0 - 1 = 32'hFFFFFFFF.

## Timing
- **Latency:** a request accepted in cycle T has its operands on the ALU in T+1 and its response valid in T+2.
- **Throughput:** 1 operation per cycle.
- **Reset values:** ALU_IN1=0, ALU_IN2=0, SEL_ALU=4'b0000, RSP0/1_VALID=0, RSP_DATA=0, RSP_ERR=0, PTR=0, S1_VALID=0.
- **READY during reset:** READY is combinational and may be high while RST is high, but no transfer is counted and PTR does not move.
- **Reset mid-operation:** in-flight S1/S2 operations are dropped, and no response is issued for them.
- **Simultaneous requests:** the requester selected by PTR wins, so back-to-back simultaneous requests alternate 0,1,0,1.
- **Response and grant in the same cycle to the same requester is legal.**
- **ALU propagation delay:** must fit within one CLK period.

## Configuration
- **ALU_ARB_ILLEGAL_CHK_EN defined:**
  - At grant, SEL is checked; legal codes are 4'b0000, 4'b1000, 4'b0110, 4'b0111.
  - An illegal code is still accepted. The operand registers are not updated, SEL_ALU is held, and S1 carries an error flag.
  - Two cycles later the response has RSP_ERR=1 and RSP_DATA=0.
- **Macro undefined:**
  - No check is performed; RSP_ERR is tied to 0.
  - An illegal code passes to the ALU, and the resulting RSP_DATA is X.

## Structure
- **Package alu_arb_pkg:**
  - Select constants OP_ADD=4'b0000, OP_SUB=4'b1000, OP_OR=4'b0110, OP_AND=4'b0111.
  - Default DATA_W/SEL_W.
  - Function is_legal_sel().
- **Sub-module rr_arb2:**
  - Two-way round-robin grant logic plus the PTR flop.
  - Inputs: CLK, RST, VALID[1:0]. Outputs: GRANT[1:0].
- **Top level:** holds the S1/S2 registers and the response muxing.

## Test plan
- **Reset:** assert RST for 3 cycles while both VALIDs are high → all outputs hold their reset values and PTR=0; first cycle after release: READY0=1, READY1=0.
- **Single add:** REQ0 A=5, B=7, SEL=0000 in cycle T → SEL_ALU=0000 and ALU_IN1=5 in T+1; RSP0_VALID=1 with RSP_DATA=12 in T+2; RSP1_VALID stays 0.
- **Contention:** both requesters valid for 4 cycles, REQ0 doing ADD 1+1 and REQ1 doing SUB 0-1 → grants 0,1,0,1; responses 2, FFFFFFFF, 2, FFFFFFFF on the alternating RSP channels.
- **Back-to-back, single requester:** REQ1 issues OR (F0|0F) then AND (FF&0F) on consecutive cycles → RSP_DATA=FF then 0F on consecutive cycles.
- **Reset mid-flight:** RST asserted in the cycle after a grant → no RSP pulse ever appears for that operation.
- **Illegal select (ALU_ARB_ILLEGAL_CHK_EN):** REQ0 SEL=4'b0011 → RSP0_VALID=1, RSP_ERR=1, RSP_DATA=0; SEL_ALU unchanged from its prior value.
